// File: rtl/memory_write_ctrl.sv
// Packet write controller: pulls free block addresses from an allocator and
// writes blocks to memory as a singly linked chain, with a packet summary.
package mem_pkg;
  localparam int BLOCK_BITS = 64;
  localparam int ADDR_W     = 10;
  localparam int LEN_W      = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] next_idx;
    logic              eop;
    logic [14-ADDR_W:0] rsvd;
  } footer_t;
endpackage

module memory_write_ctrl
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BLOCK_BITS-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  alloc_req_o,
  input  logic                  alloc_gnt_i,
  input  logic [ADDR_W-1:0]     alloc_addr_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_waddr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  output logic                  pkt_valid_o,
  output logic [ADDR_W-1:0]     pkt_start_addr_o,
  output logic [LEN_W-1:0]      pkt_len_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] nxt;
  logic              cur_v;
  logic              nxt_v;
  logic              in_pkt;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] start_r;

  logic              accept;
  logic              grant;
  footer_t           footer;
  logic [LEN_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] start_next;

  // A block is only taken once its successor address is already in hand,
  // so the footer link is always known at write time.
  assign alloc_req_o = !cur_v | !nxt_v;
  assign in_ready_o  = cur_v & nxt_v;
  assign accept      = in_valid_i & in_ready_o;
  assign grant       = alloc_gnt_i & alloc_req_o;

  always_comb begin
    footer     = '0;
    cnt_next   = LEN_W'(1);
    start_next = cur;
    if (in_last_i) begin
      footer.eop = 1'b1;
    end else begin
      footer.next_idx = nxt;
    end
    if (in_pkt) begin
      start_next = start_r;
      cnt_next   = (cnt == LEN_MAX) ? cnt : cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      nxt   <= '0;
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
    end else if (accept) begin
      // The prefetched address always becomes the next write target,
      // including across a packet boundary.
      cur   <= nxt;
      nxt_v <= grant;
      if (grant) begin
        nxt <= alloc_addr_i;
      end
    end else if (grant) begin
      if (!cur_v) begin
        cur   <= alloc_addr_i;
        cur_v <= 1'b1;
      end else begin
        nxt   <= alloc_addr_i;
        nxt_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o <= accept;
      if (accept) begin
        mem_waddr_o <= cur;
        mem_wdata_o <= {in_data_i[BLOCK_BITS-1:16], footer};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt           <= 1'b0;
      cnt              <= '0;
      start_r          <= '0;
      pkt_valid_o      <= 1'b0;
      pkt_start_addr_o <= '0;
      pkt_len_o        <= '0;
    end else begin
      pkt_valid_o <= 1'b0;
      if (accept) begin
        cnt     <= cnt_next;
        start_r <= start_next;
        in_pkt  <= !in_last_i;
        if (in_last_i) begin
          pkt_valid_o      <= 1'b1;
          pkt_start_addr_o <= start_next;
          pkt_len_o        <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_write_ctrl.sv
// Bench for memory_write_ctrl: random and directed block streams checked
// against an address-order model of the linked block chain.
module tb_memory_write_ctrl;
  import mem_pkg::*;

  localparam int WW = ADDR_W + BLOCK_BITS;
  localparam int PW = ADDR_W + LEN_W + 1;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [BLOCK_BITS-1:0] in_data_i;
  logic                  in_last_i;
  logic                  alloc_req_o;
  logic                  alloc_gnt_i;
  logic [ADDR_W-1:0]     alloc_addr_i;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_waddr_o;
  logic [BLOCK_BITS-1:0] mem_wdata_o;
  logic                  pkt_valid_o;
  logic [ADDR_W-1:0]     pkt_start_addr_o;
  logic [LEN_W-1:0]      pkt_len_o;

  memory_write_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_data_i        (in_data_i),
    .in_last_i        (in_last_i),
    .alloc_req_o      (alloc_req_o),
    .alloc_gnt_i      (alloc_gnt_i),
    .alloc_addr_i     (alloc_addr_i),
    .mem_we_o         (mem_we_o),
    .mem_waddr_o      (mem_waddr_o),
    .mem_wdata_o      (mem_wdata_o),
    .pkt_valid_o      (pkt_valid_o),
    .pkt_start_addr_o (pkt_start_addr_o),
    .pkt_len_o        (pkt_len_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: addresses granted but not yet written, in grant order
  logic [ADDR_W-1:0] held_q[$];
  logic [ADDR_W-1:0] src_q[$];
  logic [WW-1:0]     exp_q[$];
  logic [PW-1:0]     exp_p_q[$];
  logic [ADDR_W-1:0] obs_addr_hist[$];
  logic [15:0]       obs_foot_hist[$];
  bit                m_in_pkt;
  int                m_cnt;
  logic [ADDR_W-1:0] m_start;
  bit                m_acc;
  int                hs_err;
  int                n_writes;

  // scoreboard
  logic [WW-1:0] sb_w;
  logic [PW-1:0] sb_p;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we_o) begin
        n_writes++;
        obs_addr_hist.push_back(mem_waddr_o);
        obs_foot_hist.push_back(mem_wdata_o[15:0]);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got addr=%0d data=%h", mem_waddr_o, mem_wdata_o);
        end else begin
          sb_w = exp_q.pop_front();
          if ({mem_waddr_o, mem_wdata_o} !== sb_w) begin
            errors++;
            $display("FAIL write_data got addr=%0d data=%h want addr=%0d data=%h",
                     mem_waddr_o, mem_wdata_o, sb_w[WW-1 -: ADDR_W], sb_w[BLOCK_BITS-1:0]);
          end
        end
      end
      if (pkt_valid_o) begin
        checks++;
        if (exp_p_q.size() == 0) begin
          errors++;
          $display("FAIL pkt_unexpected got start=%0d len=%0d", pkt_start_addr_o, pkt_len_o);
        end else begin
          sb_p = exp_p_q.pop_front();
          if ({pkt_start_addr_o, pkt_len_o, mem_we_o & mem_wdata_o[5]} !== sb_p) begin
            errors++;
            $display("FAIL pkt_info got start=%0d len=%0d eop_wr=%0b want start=%0d len=%0d eop_wr=1",
                     pkt_start_addr_o, pkt_len_o, mem_we_o & mem_wdata_o[5],
                     sb_p[PW-1 -: ADDR_W], sb_p[LEN_W:1]);
          end
        end
      end
    end
  end

  // driver: one clock cycle of stimulus, model update and handshake tally
  task automatic step(input bit v, input bit last, input bit gnt_ok);
    logic [BLOCK_BITS-1:0] d;
    logic [ADDR_W-1:0]     a;
    logic [ADDR_W-1:0]     nx;
    bit                    m_req;
    bit                    m_ready;
    d       = {$urandom, $urandom};
    m_req   = held_q.size() < 2;
    m_ready = held_q.size() == 2;
    m_acc   = 1'b0;
    in_valid_i = v;
    in_last_i  = last;
    in_data_i  = d;
    if (alloc_req_o !== m_req || in_ready_o !== m_ready) hs_err++;
    alloc_gnt_i = gnt_ok && m_req;
    if (alloc_gnt_i) begin
      alloc_addr_i = (src_q.size() != 0) ? src_q.pop_front() : ADDR_W'($urandom_range(1, 1023));
      held_q.push_back(alloc_addr_i);
    end else begin
      alloc_addr_i = ADDR_W'($urandom);
    end
    if (v && m_ready) begin
      m_acc = 1'b1;
      a  = held_q.pop_front();
      nx = held_q[0];
      if (!m_in_pkt) begin
        m_start = a;
        m_cnt   = 1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
      exp_q.push_back({a, d[BLOCK_BITS-1:16], (last ? ADDR_W'(0) : nx), last, 5'd0});
      if (last) exp_p_q.push_back({m_start, LEN_W'(m_cnt), 1'b1});
      m_in_pkt = !last;
    end
    @(posedge clk);
    #1;
    in_valid_i  = 1'b0;
    alloc_gnt_i = 1'b0;
  endtask

  task automatic send_block(input bit last);
    int n;
    n = 0;
    do begin
      step(1'b1, last, 1'b1);
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no acceptance within 50 cycles want acceptance");
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
    alloc_gnt_i = 1'b0; alloc_addr_i = '0;
    #3;
    checks++;
    if ({mem_we_o, mem_waddr_o, mem_wdata_o, pkt_valid_o, pkt_start_addr_o, pkt_len_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b addr=%0d data=%h pv=%0b start=%0d len=%0d want all 0",
               mem_we_o, mem_waddr_o, mem_wdata_o, pkt_valid_o, pkt_start_addr_o, pkt_len_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready_o !== 1'b0 || alloc_req_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got ready=%0b req=%0b want ready=0 req=1", in_ready_o, alloc_req_o);
    end
  endtask

  task automatic test_fill;
    src_q.push_back(10'd5);
    src_q.push_back(10'd9);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_one_slot got ready=%0b want 0", in_ready_o);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready_o !== 1'b1 || alloc_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_two_slots got ready=%0b req=%0b want ready=1 req=0", in_ready_o, alloc_req_o);
    end
  endtask

  task automatic test_three_block;
    int b;
    src_q.push_back(10'd3);
    src_q.push_back(10'd7);
    b = obs_addr_hist.size();
    send_block(1'b0);
    send_block(1'b0);
    send_block(1'b1);
    drain(2);
    checks++;
    if (obs_addr_hist.size() != b + 3) begin
      errors++;
      $display("FAIL three_count got %0d writes want 3", obs_addr_hist.size() - b);
    end else if (obs_addr_hist[b] !== 10'd5 || obs_addr_hist[b+1] !== 10'd9 || obs_addr_hist[b+2] !== 10'd3 ||
                 obs_foot_hist[b] !== 16'h0240 || obs_foot_hist[b+1] !== 16'h00C0 ||
                 obs_foot_hist[b+2] !== 16'h0020) begin
      errors++;
      $display("FAIL three_chain got @%0d:%h @%0d:%h @%0d:%h want @5:0240 @9:00c0 @3:0020",
               obs_addr_hist[b], obs_foot_hist[b], obs_addr_hist[b+1], obs_foot_hist[b+1],
               obs_addr_hist[b+2], obs_foot_hist[b+2]);
    end
    checks++;
    if (pkt_start_addr_o !== 10'd5 || pkt_len_o !== 8'd3) begin
      errors++;
      $display("FAIL three_pkt got start=%0d len=%0d want start=5 len=3", pkt_start_addr_o, pkt_len_o);
    end
  endtask

  task automatic test_back_to_back;
    src_q.push_back(10'd20);
    src_q.push_back(10'd21);
    send_block(1'b1);
    drain(1);
    checks++;
    if (pkt_start_addr_o !== 10'd7 || pkt_len_o !== 8'd1) begin
      errors++;
      $display("FAIL b2b_first got start=%0d len=%0d want start=7 len=1", pkt_start_addr_o, pkt_len_o);
    end
    send_block(1'b1);
    drain(1);
    checks++;
    if (pkt_start_addr_o !== 10'd20 || pkt_len_o !== 8'd1) begin
      errors++;
      $display("FAIL b2b_second got start=%0d len=%0d want start=20 len=1", pkt_start_addr_o, pkt_len_o);
    end
  endtask

  task automatic test_starve;
    int w0;
    bit ready_seen;
    send_block(1'b0);
    send_block(1'b0);
    drain(1);
    w0 = n_writes;
    ready_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (in_ready_o !== 1'b0) ready_seen = 1'b1;
    end
    checks++;
    if (n_writes != w0 || ready_seen) begin
      errors++;
      $display("FAIL starve_stall got writes=%0d ready_seen=%0b want writes=0 ready_seen=0",
               n_writes - w0, ready_seen);
    end
    send_block(1'b0);
    send_block(1'b1);
    drain(1);
    checks++;
    if (pkt_len_o !== 8'd4) begin
      errors++;
      $display("FAIL starve_len got %0d want 4", pkt_len_o);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 299; i++) send_block(1'b0);
    send_block(1'b1);
    drain(1);
    checks++;
    if (pkt_len_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_len got %0d want 255", pkt_len_o);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    drain(2);
  endtask

  task automatic test_reset_mid;
    if (m_in_pkt) begin
      send_block(1'b1);
      drain(1);
    end
    send_block(1'b0);
    send_block(1'b0);
    drain(2);
    #2;
    rst_n = 1'b0;
    held_q.delete();
    m_in_pkt = 1'b0;
    #1;
    checks++;
    if ({mem_we_o, mem_waddr_o, mem_wdata_o, pkt_valid_o, pkt_start_addr_o, pkt_len_o, in_ready_o} !== '0
        || alloc_req_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs got we=%0b addr=%0d data=%h pv=%0b start=%0d len=%0d rdy=%0b req=%0b want zeros req=1",
               mem_we_o, mem_waddr_o, mem_wdata_o, pkt_valid_o, pkt_start_addr_o, pkt_len_o,
               in_ready_o, alloc_req_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send_block(1'b0);
    send_block(1'b0);
    send_block(1'b1);
    drain(1);
    checks++;
    if (pkt_len_o !== 8'd3) begin
      errors++;
      $display("FAIL midreset_len got %0d want 3", pkt_len_o);
    end
  endtask

  initial begin
    hs_err = 0;
    n_writes = 0;
    m_in_pkt = 1'b0;
    m_cnt = 0;
    m_start = '0;
    test_reset();
    test_fill();
    test_three_block();
    test_back_to_back();
    test_starve();
    test_saturation();
    test_random();
    test_reset_mid();
    drain(2);
    checks++;
    if (hs_err != 0) begin
      errors++;
      $display("FAIL handshake got %0d cycles with wrong ready/req want 0", hs_err);
    end
    checks++;
    if (exp_q.size() != 0 || exp_p_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got writes=%0d pkts=%0d pending want 0", exp_q.size(), exp_p_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
